aemb_ifetch: RTL



---
 rtl/aemb_ifetch.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/aemb_ifetch.sv
// aemb_ifetch -- instruction fetch stage with a two-word prefetch FIFO.
//
// Purpose:
//   This stage fetches instruction words over a Wishbone-style port. Each
//   word is pushed into a 2-entry FIFO together with its word address. The
//   head of the FIFO moves into the decode register when the pipeline
//   advances.
//   A taken branch clears the FIFO. If a fetch is still outstanding when the
//   branch arrives, the stage goes to FLUSH. In FLUSH it waits for that
//   fetch's ack, drops the returned data, and only then jumps to the target.
//   An IMM-prefix instruction supplies the upper 16 bits of the extended
//   immediate for the next valid instruction.
//
// Ports:
//   gclk, grst          clock (rising edge) / asynchronous active-low reset
//   gena                pipeline advance enable
//   rBRA, rBRPC         branch taken / branch target word address
//   iwb_stb_o/adr_o     fetch strobe and word address
//   iwb_ack_i/dat_i     fetch acknowledge and instruction data
//   rOPC..rIMM          instruction fields held in the decode register
//   rSIMM               32-bit extended immediate
//   rPC, rVLD           word address of the decoded instruction / valid flag
module aemb_ifetch (
    input  logic        gclk,
    input  logic        grst,
    input  logic        gena,
    input  logic        rBRA,
    input  logic [29:0] rBRPC,
    output logic        iwb_stb_o,
    output logic [29:0] iwb_adr_o,
    input  logic        iwb_ack_i,
    input  logic [31:0] iwb_dat_i,
    output logic [5:0]  rOPC,
    output logic [4:0]  rRD,
    output logic [4:0]  rRA,
    output logic [4:0]  rRB,
    output logic [10:0] rALT,
    output logic [15:0] rIMM,
    output logic [31:0] rSIMM,
    output logic [29:0] rPC,
    output logic        rVLD
);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    localparam logic [5:0] OPC_IMM = 6'o54;

    state_t      state_q, state_d;
    logic [29:0] fpc_q, fpc_d;
    logic [29:0] tgt_q, tgt_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [61:0] fifo_q [2];   // {pc[31:2], instr[31:0]}, slot 0 is the head
    logic [61:0] fifo_d [2];
    logic        stb_q, stb_d;
    logic        vld_q, vld_d;
    logic        immv_q, immv_d;
    logic [15:0] immhi_q, immhi_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] simm_q, simm_d;
    logic [29:0] pc_q, pc_d;

    logic        acc;
    logic        br;
    logic        pop;
    logic        push;
    logic        wr_slot;
    logic [31:0] head_ins;
    logic [15:0] head_imm;

    always_comb begin
        acc      = stb_q & iwb_ack_i;
        br       = gena & rBRA;
        pop      = gena & ~rBRA & (cnt_q != 2'd0);
        // While flushing, or when a branch lands in the same cycle, the
        // returned word belongs to the old path and is dropped.
        push     = acc & (state_q == ST_RUN) & ~br;
        head_ins = fifo_q[0][31:0];
        head_imm = head_ins[15:0];

        state_d   = state_q;
        fpc_d     = fpc_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        vld_d     = vld_q;
        immv_d    = immv_q;
        immhi_d   = immhi_q;
        ins_d     = ins_q;
        simm_d    = simm_q;
        pc_d      = pc_q;

        // FIFO: the head shifts out on pop. The new word goes to the first
        // free slot that remains after that shift.
        if (pop) begin
            fifo_d[0] = fifo_q[1];
        end
        wr_slot = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
        if (push) begin
            fifo_d[wr_slot] = {fpc_q, iwb_dat_i};
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        // Fetch pointer / flush sequencing
        if (br) begin
            if (stb_q & ~iwb_ack_i) begin
                // A fetch is still in flight. Keep its address on the bus
                // until it completes, then jump.
                tgt_d   = rBRPC;
                state_d = ST_FLUSH;
            end else begin
                fpc_d   = rBRPC;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_FLUSH) begin
            if (acc) begin
                fpc_d   = tgt_q;
                state_d = ST_RUN;
            end
        end else if (acc) begin
            fpc_d = fpc_q + 30'd1;
        end

        // Decode register
        if (br) begin
            cnt_d  = 2'd0;
            vld_d  = 1'b0;
            immv_d = 1'b0;
            ins_d  = 32'd0;
            simm_d = 32'd0;
            pc_d   = 30'd0;
        end else if (gena) begin
            if (cnt_q != 2'd0) begin
                ins_d  = head_ins;
                pc_d   = fifo_q[0][61:32];
                vld_d  = 1'b1;
                // Use the IMM state that was in force before this
                // instruction loaded.
                simm_d = immv_q ? {immhi_q, head_imm}
                                : {{16{head_imm[15]}}, head_imm};
                if (head_ins[31:26] == OPC_IMM) begin
                    immv_d  = 1'b1;
                    immhi_d = head_imm;
                end else begin
                    immv_d = 1'b0;
                end
            end else begin
                // Bubble: the decode register is zeroed and the IMM prefix
                // state is kept.
                vld_d  = 1'b0;
                ins_d  = 32'd0;
                simm_d = 32'd0;
                pc_d   = 30'd0;
            end
        end

        // The strobe is registered. It tracks "FIFO not full" as of the
        // next cycle.
        stb_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state_q   <= ST_RUN;
            fpc_q     <= 30'd0;
            tgt_q     <= 30'd0;
            cnt_q     <= 2'd0;
            fifo_q[0] <= 62'd0;
            fifo_q[1] <= 62'd0;
            stb_q     <= 1'b0;
            vld_q     <= 1'b0;
            immv_q    <= 1'b0;
            immhi_q   <= 16'd0;
            ins_q     <= 32'd0;
            simm_q    <= 32'd0;
            pc_q      <= 30'd0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            stb_q     <= stb_d;
            vld_q     <= vld_d;
            immv_q    <= immv_d;
            immhi_q   <= immhi_d;
            ins_q     <= ins_d;
            simm_q    <= simm_d;
            pc_q      <= pc_d;
        end
    end

    assign iwb_stb_o = stb_q;
    assign iwb_adr_o = fpc_q;
    assign rOPC      = ins_q[31:26];
    assign rRD       = ins_q[25:21];
    assign rRA       = ins_q[20:16];
    assign rRB       = ins_q[15:11];
    assign rALT      = ins_q[10:0];
    assign rIMM      = ins_q[15:0];
    assign rSIMM     = simm_q;
    assign rPC       = pc_q;
    assign rVLD      = vld_q;

endmodule
